memory_xlen: RTL and testbench

// - Parametrised simulation memory model attached to the processor core, replacing the fixed 32-bit model.
// - Generalised to XLEN 32/64 data width, with byte-masked stores, a pipelined READ_LATENCY and misalignment exceptions.
// - Adds valid-qualified fetch/load/store channels and real LR/SC reservation tracking.

---
 rtl/memory_xlen.sv | 169 ++++++++++++++++
 tb/tb_memory_xlen.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/memory_xlen.sv
// memory_xlen: XLEN-wide simulation memory with pipelined fetch/load, byte-masked stores and LR/SC.
// Optional reservation tracking is enabled by defining MEMORY_XLEN_RESERVATION_EN.
module memory_xlen #(
   parameter int    XLEN            = 32,
   parameter int    NUM_BLOCK_BYTES = 1048576,
   parameter int    READ_LATENCY    = 1,
   parameter string INIT_FILE       = "MemoryInit.hex"
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_fetch_valid,
   input  logic [XLEN-1:0]   in_fetch_address,
   output logic              out_fetch_valid,
   output logic [31:0]       out_fetch_data,
   output logic              out_fetch_exception,
   input  logic              in_read_valid,
   input  logic              in_read_reserve,
   input  logic [XLEN-1:0]   in_read_address,
   output logic              out_read_valid,
   output logic [XLEN-1:0]   out_read_data,
   output logic              out_read_exception,
   input  logic              in_write_enable,
   input  logic              in_write_conditional,
   input  logic [XLEN-1:0]   in_write_address,
   input  logic [XLEN-1:0]   in_write_data,
   input  logic [XLEN/8-1:0] in_write_mask,
   output logic              out_write_done,
   output logic              out_write_exception,
   output logic              out_reservation
);
   localparam int              W         = XLEN / 8;
   localparam int              IW        = $clog2(NUM_BLOCK_BYTES);
   localparam logic [XLEN:0]   LIMIT     = (XLEN+1)'(NUM_BLOCK_BYTES);
   localparam logic [XLEN-1:0] WORD_MASK = ~XLEN'(W - 1);

   typedef struct packed {
      logic            valid;
      logic            exc;
      logic [31:0]     data;
   } fetch_rsp_t;

   typedef struct packed {
      logic            valid;
      logic            exc;
      logic [XLEN-1:0] data;
   } load_rsp_t;

   logic [7:0]  r_mem        [NUM_BLOCK_BYTES];
   fetch_rsp_t  r_fetch_pipe [READ_LATENCY];
   load_rsp_t   r_load_pipe  [READ_LATENCY];
   logic        r_write_done;
   logic        r_write_exc;
   logic        r_reservation;

   logic          w_fetch_fault, w_load_fault, w_write_fault;
   logic [IW-1:0] w_fetch_index, w_load_index, w_write_index;
   fetch_rsp_t    w_fetch_rsp;
   load_rsp_t     w_load_rsp;
   logic          w_commit;
   logic          w_rsp_resv;

   // Bounds are checked one bit wider than the address so a wrapping access faults.
   function automatic logic f_fault(input logic [XLEN-1:0] addr, input logic [XLEN-1:0] size);
      logic [XLEN:0] end_addr;
      end_addr = {1'b0, addr} + {1'b0, size};
      return ((addr & (size - 1'b1)) != '0) || (end_addr > LIMIT);
   endfunction

   assign w_fetch_fault = f_fault(in_fetch_address, XLEN'(4));
   assign w_load_fault  = f_fault(in_read_address,  XLEN'(W));
   assign w_write_fault = f_fault(in_write_address, XLEN'(W));
   assign w_fetch_index = in_fetch_address[IW-1:0];
   assign w_load_index  = in_read_address[IW-1:0];
   assign w_write_index = in_write_address[IW-1:0];

   // NOTE: every field gets a default before the loops, so no latch is inferred.
   always_comb begin
      w_fetch_rsp       = '0;
      w_load_rsp        = '0;
      w_fetch_rsp.valid = in_fetch_valid;
      w_fetch_rsp.exc   = in_fetch_valid && w_fetch_fault;
      w_load_rsp.valid  = in_read_valid;
      w_load_rsp.exc    = in_read_valid && w_load_fault;
      for (int i = 0; i < 4; i++) begin
         w_fetch_rsp.data[8*i +: 8] = r_mem[w_fetch_index + IW'(i)];
      end
      for (int i = 0; i < W; i++) begin
         w_load_rsp.data[8*i +: 8] = r_mem[w_load_index + IW'(i)];
      end
      if (w_fetch_fault) w_fetch_rsp.data = '0;
      if (w_load_fault)  w_load_rsp.data  = '0;
   end

`ifdef MEMORY_XLEN_RESERVATION_EN
   logic            r_resv_valid;
   logic [XLEN-1:0] r_resv_addr;
   logic            w_sc_ok;
   logic [XLEN-1:0] w_store_word;

   assign w_store_word = in_write_address & WORD_MASK;
   assign w_sc_ok      = r_resv_valid && (r_resv_addr == w_store_word) && !w_write_fault;
   assign w_commit     = in_write_enable && !w_write_fault && (!in_write_conditional || w_sc_ok);
   assign w_rsp_resv   = in_write_conditional ? w_sc_ok : 1'b1;

   // NOTE: the LR set is written after the store clear, so the later non-blocking update wins.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_resv_valid <= 1'b0;
         r_resv_addr  <= '0;
      end else begin
         if (in_write_enable && (in_write_conditional ||
             (w_commit && (in_write_mask != '0) && (w_store_word == r_resv_addr)))) begin
            r_resv_valid <= 1'b0;
         end
         if (in_read_valid && in_read_reserve && !w_load_fault) begin
            r_resv_valid <= 1'b1;
            r_resv_addr  <= in_read_address & WORD_MASK;
         end
      end
   end
`else
   logic w_unused;
   assign w_unused   = &{1'b0, in_read_reserve, in_write_conditional};
   assign w_commit   = in_write_enable && !w_write_fault;
   assign w_rsp_resv = !w_write_fault;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int s = 0; s < READ_LATENCY; s++) begin
            r_fetch_pipe[s] <= '0;
            r_load_pipe[s]  <= '0;
         end
         r_write_done  <= 1'b0;
         r_write_exc   <= 1'b0;
         r_reservation <= 1'b0;
      end else begin
         r_fetch_pipe[0] <= w_fetch_rsp;
         r_load_pipe[0]  <= w_load_rsp;
         for (int s = 1; s < READ_LATENCY; s++) begin
            r_fetch_pipe[s] <= r_fetch_pipe[s-1];
            r_load_pipe[s]  <= r_load_pipe[s-1];
         end
         r_write_done  <= in_write_enable;
         r_write_exc   <= in_write_enable && w_write_fault;
         r_reservation <= in_write_enable && w_rsp_resv;
      end
   end

   // NOTE: the byte array is deliberately left out of reset; only control state is cleared.
   always_ff @(posedge clk) begin
      if (!reset && w_commit) begin
         for (int i = 0; i < W; i++) begin
            if (in_write_mask[i]) r_mem[w_write_index + IW'(i)] <= in_write_data[8*i +: 8];
         end
      end
   end

   assign out_fetch_valid     = r_fetch_pipe[READ_LATENCY-1].valid;
   assign out_fetch_exception = r_fetch_pipe[READ_LATENCY-1].exc;
   assign out_fetch_data      = r_fetch_pipe[READ_LATENCY-1].data;
   assign out_read_valid      = r_load_pipe[READ_LATENCY-1].valid;
   assign out_read_exception  = r_load_pipe[READ_LATENCY-1].exc;
   assign out_read_data       = r_load_pipe[READ_LATENCY-1].data;
   assign out_write_done      = r_write_done;
   assign out_write_exception = r_write_exc;
   assign out_reservation     = r_reservation;

endmodule

// File: tb/tb_memory_xlen.sv
// tb_memory_xlen: directed and random traffic against a byte-array / queue reference model.
`timescale 1ns/1ps
module tb_memory_xlen;
   localparam int XLEN = 64;
   localparam int W    = XLEN / 8;
   localparam int LAT  = 2;
   localparam int NB   = 4096;

   typedef struct {
      logic        valid;
      logic        exc;
      logic        all;
      logic [63:0] data;
   } rsp_t;

   typedef struct {
      logic done;
      logic exc;
      logic resv;
      logic all;
   } wr_t;

   logic            clk = 1'b0;
   logic            reset;
   logic            in_fetch_valid;
   logic [XLEN-1:0] in_fetch_address;
   logic            out_fetch_valid;
   logic [31:0]     out_fetch_data;
   logic            out_fetch_exception;
   logic            in_read_valid;
   logic            in_read_reserve;
   logic [XLEN-1:0] in_read_address;
   logic            out_read_valid;
   logic [XLEN-1:0] out_read_data;
   logic            out_read_exception;
   logic            in_write_enable;
   logic            in_write_conditional;
   logic [XLEN-1:0] in_write_address;
   logic [XLEN-1:0] in_write_data;
   logic [W-1:0]    in_write_mask;
   logic            out_write_done;
   logic            out_write_exception;
   logic            out_reservation;

   int          total = 0;
   int          bad   = 0;
   logic [7:0]  model_mem [NB];
   rsp_t        fetch_q [$];
   rsp_t        load_q  [$];
   wr_t         wr_q    [$];
   logic        resv_valid = 1'b0;
   logic [63:0] resv_word  = '0;
   logic [63:0] pre;

   always #5 clk = ~clk;

   memory_xlen #(.XLEN(XLEN), .NUM_BLOCK_BYTES(NB), .READ_LATENCY(LAT)) dut (
      .clk(clk), .reset(reset),
      .in_fetch_valid(in_fetch_valid), .in_fetch_address(in_fetch_address),
      .out_fetch_valid(out_fetch_valid), .out_fetch_data(out_fetch_data),
      .out_fetch_exception(out_fetch_exception),
      .in_read_valid(in_read_valid), .in_read_reserve(in_read_reserve),
      .in_read_address(in_read_address), .out_read_valid(out_read_valid),
      .out_read_data(out_read_data), .out_read_exception(out_read_exception),
      .in_write_enable(in_write_enable), .in_write_conditional(in_write_conditional),
      .in_write_address(in_write_address), .in_write_data(in_write_data),
      .in_write_mask(in_write_mask), .out_write_done(out_write_done),
      .out_write_exception(out_write_exception), .out_reservation(out_reservation)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // An access faults when misaligned or when any byte lies past the array end.
   function automatic logic fault(input logic [63:0] a, input int size);
      logic [64:0] end_addr;
      end_addr = {1'b0, a} + 65'(size);
      return ((a % 64'(size)) != 0) || (end_addr > 65'(NB));
   endfunction

   function automatic logic [63:0] read_bytes(input logic [63:0] a, input int n);
      logic [63:0] v;
      v = '0;
      for (int i = n - 1; i >= 0; i--) v = (v << 8) | 64'(model_mem[int'(a[31:0]) + i]);
      return v;
   endfunction

   task automatic clr();
      in_fetch_valid = 0; in_fetch_address = '0;
      in_read_valid = 0; in_read_reserve = 0; in_read_address = '0;
      in_write_enable = 0; in_write_conditional = 0; in_write_address = '0;
      in_write_data = '0; in_write_mask = '0;
   endtask

   task automatic fe(input logic [63:0] a);
      in_fetch_valid = 1; in_fetch_address = a;
   endtask

   task automatic ld(input logic [63:0] a, input logic rsv);
      in_read_valid = 1; in_read_reserve = rsv; in_read_address = a;
   endtask

   task automatic st(input logic [63:0] a, input logic [63:0] d, input logic [7:0] m, input logic sc);
      in_write_enable = 1; in_write_conditional = sc; in_write_address = a;
      in_write_data = d; in_write_mask = m;
   endtask

   // One clock: predict from current inputs, advance, compare what is due, clear inputs.
   task automatic cycle();
      rsp_t        f, l;
      wr_t         w;
      logic        commit;
      logic [63:0] word;
      f = '{default: '0};
      l = '{default: '0};
      w = '{default: '0};
      if (reset) begin
         fetch_q.delete(); load_q.delete(); wr_q.delete();
         f.all = 1; w.all = 1;
         for (int i = 0; i < LAT; i++) begin
            fetch_q.push_back(f);
            load_q.push_back(f);
         end
         wr_q.push_back(w);
         resv_valid = 0;
      end else begin
         if (in_fetch_valid) begin
            f.valid = 1;
            f.exc   = fault(in_fetch_address, 4);
            f.data  = f.exc ? '0 : read_bytes(in_fetch_address, 4);
         end
         if (in_read_valid) begin
            l.valid = 1;
            l.exc   = fault(in_read_address, W);
            l.data  = l.exc ? '0 : read_bytes(in_read_address, W);
         end
         if (in_write_enable) begin
            w.done = 1;
            w.exc  = fault(in_write_address, W);
            word   = in_write_address & ~64'(W - 1);
`ifdef MEMORY_XLEN_RESERVATION_EN
            begin
               logic ok;
               ok     = resv_valid && (resv_word == word) && !w.exc;
               commit = !w.exc && (!in_write_conditional || ok);
               w.resv = in_write_conditional ? ok : 1'b1;
               if (in_write_conditional || (commit && in_write_mask != 0 && word == resv_word))
                  resv_valid = 0;
            end
`else
            commit = !w.exc;
            w.resv = !w.exc;
`endif
            if (commit) begin
               for (int i = 0; i < W; i++)
                  if (in_write_mask[i]) model_mem[int'(word[31:0]) + i] = in_write_data[8*i +: 8];
            end
         end
`ifdef MEMORY_XLEN_RESERVATION_EN
         if (in_read_valid && in_read_reserve && !l.exc) begin
            resv_valid = 1;
            resv_word  = in_read_address & ~64'(W - 1);
         end
`endif
         fetch_q.push_back(f);
         load_q.push_back(l);
         wr_q.push_back(w);
      end
      @(posedge clk); #1;
      f = fetch_q.pop_front();
      l = load_q.pop_front();
      w = wr_q.pop_front();
      check("fetch_valid", 64'(out_fetch_valid), 64'(f.valid));
      if (f.valid || f.all) begin
         check("fetch_exc", 64'(out_fetch_exception), 64'(f.exc));
         check("fetch_data", 64'(out_fetch_data), f.data);
      end
      check("load_valid", 64'(out_read_valid), 64'(l.valid));
      if (l.valid || l.all) begin
         check("load_exc", 64'(out_read_exception), 64'(l.exc));
         check("load_data", out_read_data, l.data);
      end
      check("write_done", 64'(out_write_done), 64'(w.done));
      if (w.done || w.all) begin
         check("write_exc", 64'(out_write_exception), 64'(w.exc));
         check("reservation", 64'(out_reservation), 64'(w.resv));
      end
      clr();
   endtask

   function automatic logic [63:0] rand_addr(input int size);
      case ($urandom_range(0, 9))
         0:       return 64'($urandom_range(0, 255));
         1:       return 64'(NB - $urandom_range(1, 8));
         2:       return 64'hFFFF_FFFF_FFFF_FFF8;
         default: return 64'($urandom_range(0, 31) * size);
      endcase
   endfunction

   initial begin
      clr();
      reset = 1;
      repeat (3) cycle();
      reset = 0;

      // Preload a known image through the store port.
      for (int a = 0; a < NB; a += W) begin
         st(64'(a), {$urandom, $urandom}, 8'hFF, 0);
         cycle();
      end
      cycle();

      // Load latency is exactly LAT cycles.
      ld(64'h10, 0); cycle();
      check("lat_not_early", 64'(out_read_valid), 64'd0);
      cycle();
      check("lat_valid", 64'(out_read_valid), 64'd1);
      check("lat_data", out_read_data, read_bytes(64'h10, 8));

      // Back-to-back loads respond in consecutive cycles.
      ld(64'h10, 0); cycle();
      ld(64'h18, 0); cycle();
      check("b2b_first", out_read_data, read_bytes(64'h10, 8));
      cycle();
      check("b2b_second", out_read_data, read_bytes(64'h18, 8));

      // Byte-masked store keeps the upper half.
      pre = read_bytes(64'h20, 8);
      st(64'h20, 64'hAABBCCDD_11223344, 8'h0F, 0); cycle();
      ld(64'h20, 0); cycle(); cycle();
      check("mask_word", out_read_data, {pre[63:32], 32'h11223344});

      // Faulting store, faulting load/fetch, wrapping load.
      pre = read_bytes(64'h20, 8);
      st(64'h22, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 0); ld(64'(NB - 2), 0); fe(64'(NB - 2)); cycle();
      check("st_fault", 64'(out_write_exception), 64'd1);
      ld(64'hFFFF_FFFF_FFFF_FFF8, 0); fe(64'h22); cycle();
      check("ld_fault", 64'(out_read_exception), 64'd1);
      check("ld_fault_data", out_read_data, 64'd0);
      ld(64'h20, 0); fe(64'(NB - 4)); cycle(); cycle();
      check("fault_no_write", out_read_data, pre);
      check("fetch_last_word", 64'(out_fetch_exception), 64'd0);

      // LR then SC succeeds.
      ld(64'h40, 1); cycle();
      st(64'h40, 64'h0123_4567_89AB_CDEF, 8'hFF, 1); cycle();
      check("sc_pass", 64'(out_reservation), 64'd1);

      // LR, plain store to the upper half of the word, then SC.
      ld(64'h40, 1); cycle();
      st(64'h40, 64'h5555_6666_0000_0000, 8'hF0, 0); cycle();
      pre = read_bytes(64'h40, 8);
      st(64'h40, 64'hDEAD_BEEF_DEAD_BEEF, 8'hFF, 1); cycle();
`ifdef MEMORY_XLEN_RESERVATION_EN
      check("sc_after_store", 64'(out_reservation), 64'd0);
`else
      check("sc_after_store", 64'(out_reservation), 64'd1);
`endif
      ld(64'h40, 0); cycle(); cycle();
      check("sc_mem", out_read_data, read_bytes(64'h40, 8));

      // Mask-0 store keeps the reservation; same-cycle LR and store leave it valid.
      ld(64'h48, 1); cycle();
      st(64'h48, 64'h1, 8'h00, 0); cycle();
      st(64'h48, 64'h7777_8888_9999_AAAA, 8'hFF, 1); cycle();
      check("sc_mask0", 64'(out_reservation), 64'd1);
      ld(64'h50, 1); st(64'h50, 64'h1234, 8'h03, 0); cycle();
      st(64'h50, 64'h4321, 8'h03, 1); cycle();
      check("sc_lr_same_cycle", 64'(out_reservation), 64'd1);

      // Same-cycle load and store: old data first, new data next.
      pre = read_bytes(64'h80, 8);
      ld(64'h80, 0); st(64'h80, 64'hCAFE_F00D_CAFE_F00D, 8'hFF, 0); cycle();
      ld(64'h80, 0); cycle();
      check("rbw_old", out_read_data, pre);
      cycle();
      check("rbw_new", out_read_data, 64'hCAFE_F00D_CAFE_F00D);

      // Reset mid-flight: responses dropped, no store, reservation cleared.
      pre = read_bytes(64'h88, 8);
      ld(64'h40, 1); cycle();
      ld(64'h88, 0); reset = 1; st(64'h88, 64'h0BAD_0BAD_0BAD_0BAD, 8'hFF, 0); cycle();
      reset = 0;
      check("reset_drop", 64'(out_read_valid), 64'd0);
      st(64'h40, 64'h0, 8'hFF, 1); cycle();
`ifdef MEMORY_XLEN_RESERVATION_EN
      check("reset_resv", 64'(out_reservation), 64'd0);
`else
      check("reset_resv", 64'(out_reservation), 64'd1);
`endif
      ld(64'h88, 0); cycle(); cycle();
      check("reset_no_store", out_read_data, pre);

      // Random traffic on all channels.
      for (int n = 0; n < 400; n++) begin
         if ($urandom_range(0, 1) == 1) fe(rand_addr(4));
         if ($urandom_range(0, 1) == 1) ld(rand_addr(W), 1'($urandom_range(0, 2) == 0));
         if ($urandom_range(0, 2) == 0)
            st(rand_addr(W), {$urandom, $urandom}, 8'($urandom), 1'($urandom_range(0, 2) == 0));
         cycle();
      end
      repeat (LAT) cycle();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
